// File: rtl/des_pkg.sv
// DES key-schedule constants and FSM state type.
// Bit tables are 0-based: entry n holds (DES bit number - 1).
package des_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GEN,
    S_DONE
  } state_t;

  localparam int unsigned PC1 [56] = '{
    56, 48, 40, 32, 24, 16,  8,
     0, 57, 49, 41, 33, 25, 17,
     9,  1, 58, 50, 42, 34, 26,
    18, 10,  2, 59, 51, 43, 35,
    62, 54, 46, 38, 30, 22, 14,
     6, 61, 53, 45, 37, 29, 21,
    13,  5, 60, 52, 44, 36, 28,
    20, 12,  4, 27, 19, 11,  3
  };

  localparam int unsigned PC2 [48] = '{
    13, 16, 10, 23,  0,  4,
     2, 27, 14,  5, 20,  9,
    22, 18, 11,  3, 25,  7,
    15,  6, 26, 19, 12,  1,
    40, 51, 30, 36, 46, 54,
    29, 39, 50, 44, 32, 47,
    43, 48, 38, 55, 33, 52,
    45, 41, 49, 35, 28, 31
  };

  localparam int unsigned SHIFT [16] = '{
    1, 1, 2, 2, 2, 2, 2, 2,
    1, 2, 2, 2, 2, 2, 2, 1
  };

endpackage

// File: rtl/des_key_schedule_if.sv
// Key-load request and round-key valid/ready stream.
// master drives loads and accepts keys; slave is the schedule.
interface des_key_schedule_if;

  logic [63:0] key_in;
  logic        decrypt;
  logic        start;
  logic        busy;
  logic        rk_valid;
  logic        rk_ready;
  logic [47:0] rk_out;
  logic [3:0]  rk_round;
  logic        done;
  logic        parity_err;

  modport master (
    output key_in, decrypt, start, rk_ready,
    input  busy, rk_valid, rk_out, rk_round,
    input  done, parity_err
  );

  modport slave (
    input  key_in, decrypt, start, rk_ready,
    output busy, rk_valid, rk_out, rk_round,
    output done, parity_err
  );

endinterface

// File: rtl/des_pc2.sv
// Combinational PC-2: selects 48 of the 56 C||D bits.
// Bit n-1 of each vector is DES bit n.
module des_pc2
  import des_pkg::*;
(
  input  logic [55:0] i_cd,
  output logic [47:0] o_rk
);

  for (genvar g = 0; g < 48; g++) begin : g_pc2
    assign o_rk[g] = i_cd[PC2[g]];
  end

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES round-key generator, one key per handshake,
// encrypt (K1..KN) or decrypt (K16 downward) order.
module des_key_schedule
  import des_pkg::*;
#(
  parameter int NUM_ROUNDS   = 16,
  parameter bit PARITY_CHECK = 1'b1
) (
  input logic               clk,
  input logic               rst,
  des_key_schedule_if.slave bus
);

  localparam logic [3:0] LAST = 4'(NUM_ROUNDS - 1);

  state_t      r_state;
  state_t      w_next;
  logic [27:0] r_c;
  logic [27:0] r_d;
  logic [3:0]  r_cnt;
  logic        r_dec;
  logic        r_par;

  logic [55:0] w_pc1;
  logic        w_accept;
  logic        w_hs;
  logic        w_last;
  logic [3:0]  w_sidx;
  logic        w_two;
  logic        w_perr;

  // DES rotate-left moves bit 1 toward bit 28, i.e. down in index
  function automatic logic [27:0] rol(
    input logic [27:0] v,
    input logic        two
  );
    return two ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
  endfunction

  function automatic logic [27:0] ror(
    input logic [27:0] v,
    input logic        two
  );
    return two ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
  endfunction

  for (genvar g = 0; g < 56; g++) begin : g_pc1
    assign w_pc1[g] = bus.key_in[PC1[g]];
  end

  always_comb begin
    w_perr = 1'b0;
    for (int b = 0; b < 8; b++) begin
      w_perr = w_perr | ~(^bus.key_in[8*b +: 8]);
    end
    w_perr = PARITY_CHECK ? w_perr : 1'b0;
  end

  assign w_accept = (r_state == S_IDLE) && bus.start;
  assign w_hs     = (r_state == S_GEN) && bus.rk_ready;
  assign w_last   = (r_cnt == LAST);

  // shift for the step into the next emitted round
  assign w_sidx = r_dec ? (4'd15 - r_cnt) : (r_cnt + 4'd1);
  assign w_two  = (SHIFT[w_sidx] == 32'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.start) w_next = S_GEN;
      S_GEN:   if (bus.rk_ready && w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // encrypt preloads the round-1 rotate so K1 is ready next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_c   <= '0;
      r_d   <= '0;
      r_cnt <= '0;
      r_dec <= 1'b0;
      r_par <= 1'b0;
    end else if (w_accept) begin
      r_c   <= bus.decrypt ? w_pc1[27:0]  : rol(w_pc1[27:0], 1'b0);
      r_d   <= bus.decrypt ? w_pc1[55:28] : rol(w_pc1[55:28], 1'b0);
      r_cnt <= '0;
      r_dec <= bus.decrypt;
      r_par <= w_perr;
    end else if (w_hs && !w_last) begin
      r_c   <= r_dec ? ror(r_c, w_two) : rol(r_c, w_two);
      r_d   <= r_dec ? ror(r_d, w_two) : rol(r_d, w_two);
      r_cnt <= r_cnt + 4'd1;
    end
  end

  des_pc2 u_pc2 (
    .i_cd ({r_d, r_c}),
    .o_rk (bus.rk_out)
  );

  assign bus.busy       = (r_state == S_GEN);
  assign bus.rk_valid   = (r_state == S_GEN);
  assign bus.done       = (r_state == S_DONE);
  assign bus.rk_round   = r_dec ? (4'd15 - r_cnt) : r_cnt;
  assign bus.parity_err = r_par;

endmodule
